merge_rr: RTL and testbench

//  N-master to 1-slave native-bus merge with registered round-robin arbitration.

---
 rtl/merge_rr_if.sv | 32 +++
 rtl/merge_rr.sv | 103 ++++++++++
 tb/tb_merge_rr.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/merge_rr_if.sv
// Bus bundle for merge_rr: N master request/response lanes plus the single merged slave lane.
// Request = {valid, addr, wdata, wstrb}; response = {rdata, ready}.
interface merge_rr_if #(
  parameter int unsigned N_MASTERS = 2
) ();
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned STRB_W = DATA_W / 8;
  localparam int unsigned REQ_W  = 1 + ADDR_W + DATA_W + STRB_W;
  localparam int unsigned RESP_W = DATA_W + 1;

  logic [N_MASTERS*REQ_W-1:0]  m_req;
  logic [N_MASTERS*RESP_W-1:0] m_resp;
  logic [REQ_W-1:0]            s_req;
  logic [RESP_W-1:0]           s_resp;

  // Environment side: drives master requests and the slave response.
  modport master (
    output m_req,
    input  m_resp,
    input  s_req,
    output s_resp
  );

  // Merge side: consumes master requests, drives the merged request.
  modport slave (
    input  m_req,
    output m_resp,
    output s_req,
    input  s_resp
  );
endinterface

// File: rtl/merge_rr.sv
// N-master to 1-slave bus merge with registered round-robin arbitration; grant held until ready.
// Define MERGE_FIXED_PRIO_EN for fixed lowest-index-wins arbitration instead of round-robin.
module merge_rr #(
  parameter int unsigned N_MASTERS = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  merge_rr_if.slave  bus
);
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned STRB_W = DATA_W / 8;
  localparam int unsigned REQ_W  = 1 + ADDR_W + DATA_W + STRB_W;
  localparam int unsigned RESP_W = DATA_W + 1;
  localparam int unsigned NB     = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t               fsm;
  logic [NB-1:0]        gnt;
  logic [NB-1:0]        sel;
  logic                 any_valid;
  logic [N_MASTERS-1:0] valid;
  logic [REQ_W-1:0]     req_arr [N_MASTERS];
`ifndef MERGE_FIXED_PRIO_EN
  logic [NB-1:0]        ptr;
  int                   idx;
`endif

  // Unpack master lanes and their valid bits.
  always_comb begin
    for (int i = 0; i < int'(N_MASTERS); i++) begin
      req_arr[i] = bus.m_req[i*int'(REQ_W) +: REQ_W];
      valid[i]   = req_arr[i][REQ_W-1];
    end
  end

  // Arbitration: scan from highest to lowest preference so the most preferred valid wins last.
  always_comb begin
    any_valid = 1'b0;
    sel       = '0;
`ifdef MERGE_FIXED_PRIO_EN
    for (int k = int'(N_MASTERS) - 1; k >= 0; k--) begin
      if (valid[k]) begin
        any_valid = 1'b1;
        sel       = NB'(k);
      end
    end
`else
    idx = 0;
    for (int k = int'(N_MASTERS); k >= 1; k--) begin
      idx = (int'(ptr) + k) % int'(N_MASTERS);
      if (valid[idx]) begin
        any_valid = 1'b1;
        sel       = NB'(idx);
      end
    end
`endif
  end

  // Granted lane is routed straight through while BUSY; everything else reads zero.
  always_comb begin
    bus.s_req  = '0;
    bus.m_resp = '0;
    if (fsm == BUSY) begin
      bus.s_req = req_arr[gnt];
      for (int i = 0; i < int'(N_MASTERS); i++) begin
        if (gnt == NB'(i)) begin
          bus.m_resp[i*int'(RESP_W) +: RESP_W] = bus.s_resp;
        end
      end
    end
  end

  // Grant FSM: capture on any valid, release on ready or on the granted master abandoning.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fsm <= IDLE;
      gnt <= '0;
`ifndef MERGE_FIXED_PRIO_EN
      ptr <= NB'(N_MASTERS - 1);
`endif
    end else begin
      case (fsm)
        IDLE: begin
          if (any_valid) begin
            gnt <= sel;
            fsm <= BUSY;
          end
        end
        BUSY: begin
          if (bus.s_resp[0] || !valid[gnt]) begin
            fsm <= IDLE;
`ifndef MERGE_FIXED_PRIO_EN
            ptr <= gnt;
`endif
          end
        end
        default: fsm <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_merge_rr.sv
// Randomized check of merge_rr at N_MASTERS = 2, 4 and 1 against a transaction-level reference model.
module tb_merge_rr;
  localparam int unsigned REQ_W  = 69;
  localparam int unsigned RESP_W = 33;
  localparam int NI    = 3;
  localparam int MAXN  = 4;
  localparam int NCYC  = 4000;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [REQ_W-1:0]  drv_req  [NI][MAXN];
  logic [RESP_W-1:0] drv_resp [NI];
  logic [REQ_W-1:0]  obs_sreq [NI];
  logic [RESP_W-1:0] obs_resp [NI][MAXN];

  merge_rr_if #(.N_MASTERS(2)) bus2 ();
  merge_rr_if #(.N_MASTERS(4)) bus4 ();
  merge_rr_if #(.N_MASTERS(1)) bus1 ();

  merge_rr #(.N_MASTERS(2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));
  merge_rr #(.N_MASTERS(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));
  merge_rr #(.N_MASTERS(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

  assign bus2.m_req  = {drv_req[0][1], drv_req[0][0]};
  assign bus2.s_resp = drv_resp[0];
  assign bus4.m_req  = {drv_req[1][3], drv_req[1][2], drv_req[1][1], drv_req[1][0]};
  assign bus4.s_resp = drv_resp[1];
  assign bus1.m_req  = drv_req[2][0];
  assign bus1.s_resp = drv_resp[2];

  assign obs_sreq[0] = bus2.s_req;
  assign obs_sreq[1] = bus4.s_req;
  assign obs_sreq[2] = bus1.s_req;
  assign obs_resp[0][0] = bus2.m_resp[RESP_W-1:0];
  assign obs_resp[0][1] = bus2.m_resp[2*RESP_W-1:RESP_W];
  assign obs_resp[0][2] = '0;
  assign obs_resp[0][3] = '0;
  assign obs_resp[1][0] = bus4.m_resp[RESP_W-1:0];
  assign obs_resp[1][1] = bus4.m_resp[2*RESP_W-1:RESP_W];
  assign obs_resp[1][2] = bus4.m_resp[3*RESP_W-1:2*RESP_W];
  assign obs_resp[1][3] = bus4.m_resp[4*RESP_W-1:3*RESP_W];
  assign obs_resp[2][0] = bus1.m_resp[RESP_W-1:0];
  assign obs_resp[2][1] = '0;
  assign obs_resp[2][2] = '0;
  assign obs_resp[2][3] = '0;

  // Reference model: who owns the bus, and who was served last.
  bit               owned     [NI];
  int               owner     [NI];
  int               last_srv  [NI];
  bit               pend      [NI][MAXN];
  logic [REQ_W-1:0] preq      [NI][MAXN];
  int               sl_cnt    [NI];
  int               sl_lat    [NI];
  int               done      [NI];
  bit               was_rst;
  int               n_vec = 0;
  int               n_err = 0;

  function automatic int n_of(int i);
    case (i)
      0:       return 2;
      1:       return 4;
      default: return 1;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Next owner: first requester after the last one served (or lowest index in fixed-priority builds).
  function automatic int pick(int i);
    int n = n_of(i);
`ifdef MERGE_FIXED_PRIO_EN
    for (int k = 0; k < n; k++)
      if (drv_req[i][k][REQ_W-1]) return k;
`else
    for (int k = 1; k <= n; k++) begin
      int m = (last_srv[i] + k) % n;
      if (drv_req[i][m][REQ_W-1]) return m;
    end
`endif
    return -1;
  endfunction

  // Advance masters and model across the clock edge using the inputs held during the last cycle.
  task automatic step_model(input int i);
    int n = n_of(i);
    int s;
    for (int m = 0; m < n; m++)
      if (pend[i][m] && owned[i] && owner[i] == m && drv_resp[i][0]) begin
        pend[i][m] = 1'b0;
        done[i]++;
      end
    if (!rst_n) begin
      owned[i]    = 1'b0;
      owner[i]    = 0;
      last_srv[i] = n - 1;
      sl_cnt[i]   = 0;
    end else if (!owned[i]) begin
      s = pick(i);
      if (s >= 0) begin
        owned[i] = 1'b1;
        owner[i] = s;
      end
    end else if (drv_resp[i][0] || !drv_req[i][owner[i]][REQ_W-1]) begin
      owned[i] = 1'b0;
`ifndef MERGE_FIXED_PRIO_EN
      last_srv[i] = owner[i];
`endif
    end
  endtask

  task automatic drive_masters(input int i);
    int n = n_of(i);
    for (int m = 0; m < MAXN; m++) begin
      if (m >= n) begin
        drv_req[i][m] = '0;
      end else begin
        if (pend[i][m] && $urandom_range(0, 39) == 0) begin
          pend[i][m] = 1'b0;
        end else if (!pend[i][m] && $urandom_range(0, 2) != 0) begin
          pend[i][m] = 1'b1;
          preq[i][m] = {1'b1, $urandom(), $urandom(), 4'($urandom())};
        end
        drv_req[i][m] = pend[i][m] ? preq[i][m]
                                   : {1'b0, 68'({$urandom(), $urandom(), $urandom()})};
      end
    end
  endtask

  // Slave: ready after 0..3 wait cycles per transaction, occasional stray ready when nothing is offered.
  task automatic drive_slave(input int i);
    bit sv = owned[i] && drv_req[i][owner[i]][REQ_W-1];
    if (sv) begin
      if (sl_cnt[i] >= sl_lat[i]) begin
        drv_resp[i] = {$urandom(), 1'b1};
        sl_cnt[i]   = 0;
        sl_lat[i]   = $urandom_range(0, 3);
      end else begin
        sl_cnt[i]++;
        drv_resp[i] = {$urandom(), 1'b0};
      end
    end else begin
      sl_cnt[i]   = 0;
      drv_resp[i] = {$urandom(), ($urandom_range(0, 15) == 0)};
    end
  endtask

  task automatic check_outputs(input int i);
    int n = n_of(i);
    logic [REQ_W-1:0]  es;
    logic [RESP_W-1:0] er;
    es = owned[i] ? drv_req[i][owner[i]] : '0;
    chk($sformatf("s_req[n=%0d]", n), 128'(obs_sreq[i]), 128'(es));
    for (int m = 0; m < n; m++) begin
      er = (owned[i] && owner[i] == m) ? drv_resp[i] : '0;
      chk($sformatf("m_resp%0d[n=%0d]", m, n), 128'(obs_resp[i][m]), 128'(er));
    end
    if (was_rst) begin
      chk($sformatf("rst_s_req[n=%0d]", n), 128'(obs_sreq[i]), 128'(0));
      for (int m = 0; m < n; m++)
        chk($sformatf("rst_m_resp%0d[n=%0d]", m, n), 128'(obs_resp[i][m]), 128'(0));
    end
  endtask

  initial begin
    rst_n = 1'b0;
    for (int i = 0; i < NI; i++) begin
      owned[i]    = 1'b0;
      owner[i]    = 0;
      last_srv[i] = n_of(i) - 1;
      sl_cnt[i]   = 0;
      sl_lat[i]   = 1;
      done[i]     = 0;
      drv_resp[i] = '0;
      for (int m = 0; m < MAXN; m++) begin
        pend[i][m]    = 1'b0;
        preq[i][m]    = '0;
        drv_req[i][m] = '0;
      end
    end

    for (int cyc = 0; cyc < NCYC; cyc++) begin
      @(posedge clk);
      #1;
      was_rst = !rst_n;
      for (int i = 0; i < NI; i++) step_model(i);
      rst_n = (cyc < 2 || $urandom_range(0, 79) == 0) ? 1'b0 : 1'b1;
      for (int i = 0; i < NI; i++) drive_masters(i);
      #1;
      for (int i = 0; i < NI; i++) drive_slave(i);
      #1;
      for (int i = 0; i < NI; i++) check_outputs(i);
    end

    for (int i = 0; i < NI; i++)
      chk($sformatf("served_some[n=%0d]", n_of(i)), 128'(done[i] > 100), 128'(1));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
